// File: rtl/ram_dual_port_param.sv
// Parametrised true dual-port synchronous RAM for a single clock domain.
// Two independent ports share one array. Same-address conflicts are
// resolved in port A's favour and flagged on `collision`. After every
// reset, a clear sweep writes INIT_VAL to each word while `busy` is high.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_CLEAR | sweeping INIT_VAL into word[clr_cnt]; busy=1, ports ignored
// S_RUN   | normal dual-port access; left only through reset
module ram_dual_port_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter int                RDW_MODE = 0,
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] q_a,
    output logic              valid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] q_b,
    output logic              valid_b,
    output logic              collision,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_a;
    logic              acc_b;
    logic              same_addr;
    logic              wr_a;
    logic              wr_b;
    logic              coll_nxt;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    logic [DATA_W-1:0] q1_a;
    logic [DATA_W-1:0] q1_b;
    logic              v1_a;
    logic              v1_b;
    logic              coll1;

    assign acc_a     = (state == S_RUN) && en_a;
    assign acc_b     = (state == S_RUN) && en_b;
    assign same_addr = (addr_a == addr_b);
    assign wr_a      = acc_a && we_a;
    // Port B's write is dropped when port A writes the same word.
    assign wr_b      = acc_b && we_b && !(wr_a && same_addr);
    assign coll_nxt  = acc_a && acc_b && same_addr && (we_a || we_b);
    assign busy      = (state == S_CLEAR);

    // Clear sweep sequencing: one word per edge, then run until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
        end else if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == '1) begin
                state <= S_RUN;
            end
        end
    end

    // Array writes: clear sweep, or the surviving port writes.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_cnt] <= INIT_VAL;
        end else begin
            if (wr_b) begin
                mem[addr_b] <= data_b;
            end
            if (wr_a) begin
                mem[addr_a] <= data_a;
            end
        end
    end

    // Port A read value; write-first mode forwards whichever write lands here.
    always_comb begin
        rd_a = mem[addr_a];
        if (RDW_MODE == 1) begin
            if (wr_a) begin
                rd_a = data_a;
            end else if (wr_b && same_addr) begin
                rd_a = data_b;
            end
        end
    end

    // Port B read value; A's data wins when both write the same word.
    always_comb begin
        rd_b = mem[addr_b];
        if (RDW_MODE == 1) begin
            if (wr_b) begin
                rd_b = data_b;
            end else if (wr_a && same_addr) begin
                rd_b = data_a;
            end
        end
    end

    // First output stage: q holds when the port is idle, valid pulses per access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_a  <= '0;
            q1_b  <= '0;
            v1_a  <= 1'b0;
            v1_b  <= 1'b0;
            coll1 <= 1'b0;
        end else begin
            if (acc_a) begin
                q1_a <= rd_a;
            end
            if (acc_b) begin
                q1_b <= rd_b;
            end
            v1_a  <= acc_a;
            v1_b  <= acc_b;
            coll1 <= coll_nxt;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] q2_a;
            logic [DATA_W-1:0] q2_b;
            logic              v2_a;
            logic              v2_b;
            logic              coll2;

            // Optional second stage: delays every output by one edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q2_a  <= '0;
                    q2_b  <= '0;
                    v2_a  <= 1'b0;
                    v2_b  <= 1'b0;
                    coll2 <= 1'b0;
                end else begin
                    q2_a  <= q1_a;
                    q2_b  <= q1_b;
                    v2_a  <= v1_a;
                    v2_b  <= v1_b;
                    coll2 <= coll1;
                end
            end

            assign q_a       = q2_a;
            assign q_b       = q2_b;
            assign valid_a   = v2_a;
            assign valid_b   = v2_b;
            assign collision = coll2;
        end else begin : g_no_out_reg
            assign q_a       = q1_a;
            assign q_b       = q1_b;
            assign valid_a   = v1_a;
            assign valid_b   = v1_b;
            assign collision = coll1;
        end
    endgenerate

endmodule
